dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the processor's load/store port; the memory end of the processor's data-memory interface.
- Accepts one load or store per valid/ready handshake, inserts a programmable wait-state count, then returns a response under its own valid/ready handshake.
- Holds a DEPTH x 32-bit word array with byte-enable writes.
- Replaces the single-cycle fake RAM so the processor can be moved to a multi-cycle memory protocol.

Parameters:
- ADDR_W, 5, word-address width
- DATA_W, 32, data width; must be 32 (4 byte lanes)
- DEPTH, 32, words implemented; 1..2^ADDR_W
- LATENCY, 2, wait cycles between accept and commit/response; 0..15

Ports:
- CLOCK_50  input  1  sole clock; all state changes on its rising edge
- reset_n  input  1  reset, asynchronous and active-low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  store data
- req_be  input  4  byte enables; bit i covers bits 8i+7:8i
- rsp_valid  output  1  response present
- rsp_ready  input  1  processor takes the response
- rsp_rdata  output  DATA_W  load data, or the merged word for a store
- rsp_err  output  1  address >= DEPTH
- busy  output  1  transaction in flight

Behaviour:
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE). rsp_valid = (state==RESP). busy = (state!=IDLE).
- Reset (reset_n low, asynchronous):
  - State goes to IDLE and the 4-bit counter to 0.
  - Output values during and after reset: rsp_rdata=0, rsp_err=0, req_ready=1, rsp_valid=0, busy=0.
  - Array contents are not reset. They are zero-initialised at configuration and preserved across reset.
- Accept: on an edge where req_valid && req_ready, capture we, addr, wdata and be.
  - LATENCY=0: go to RESP and commit on that same edge.
  - Otherwise: go to WAIT and load cnt=LATENCY.
- WAIT: on each edge, if cnt==1 go to RESP and commit; else cnt <= cnt-1.
- Timing: commit and rsp_valid rise on edge N+LATENCY, where N is the accept edge.
- Commit, in-range address:
  - Load: rsp_rdata <= mem[addr].
  - Store: each lane with be[i]=1 takes wdata lane i, other lanes keep their value. rsp_rdata <= the merged word.
  - be=0 store: memory unchanged; still responds with the current word.
- Commit, addr >= DEPTH: no array access, no aliasing. rsp_rdata <= 0, rsp_err <= 1.
- Commit, in range: rsp_err <= 0.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready. On that edge go to IDLE.
  - rsp_rdata and rsp_err keep their values in IDLE until the next commit.
- No overlap: req_ready is low in WAIT and RESP, and req_* is ignored there.
  - Minimum spacing is LATENCY+2 cycles between accept edges when rsp_ready is tied high.
- Request inputs are sampled only at the accept edge. Later changes to req_* do not affect the in-flight transaction.
- Reset mid-operation:
  - A store still in WAIT is dropped; its target word keeps its old value.
  - A store already committed (reset in RESP) persists.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP)
  - default ADDR_W, DATA_W, DEPTH, LATENCY
  - BE_W=4
  - the lane-merge function (old word, new word, be) -> merged word
- Sub-module dmem_array: a DEPTH x 32 array with one read port, a byte-enable write port clocked by CLOCK_50, and no reset.
- FSM, counter, capture registers and response registers stay in dmem_responder.

Test Plan:
- Store timing: LATENCY=2, rsp_ready=1. Store addr 3, data 0xDEADBEEF, be=4'hF, accepted at edge N.
  - Required: rsp_valid=1 from edge N+2 to N+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
  - Required: req_ready returns to 1 after edge N+3; busy is high across edges N to N+3.
- Load-back: load addr 3 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
  - LATENCY=0 build: rsp_valid rises on the accept edge itself.
- Partial store: store addr 3, data 0x0000AA00, be=4'b0010 -> rsp_rdata=0xDEADAAEF. A following load of addr 3 returns 0xDEADAAEF.
- Back-pressure: hold rsp_ready=0 for 5 cycles during RESP while driving req_valid=1 with addr 9 store.
  - Required: rsp_valid, rsp_rdata and rsp_err stable; req_ready=0; addr 9 unchanged.
  - After rsp_ready rises, exactly one handshake occurs, then IDLE.
- Reset during WAIT: store addr 7, data 0x12345678, LATENCY=4; pulse reset_n low 2 cycles after accept.
  - Required: outputs reach their reset values immediately (asynchronously).
  - Required: a subsequent load of addr 7 returns 0x00000000.
- Out of range: DEPTH=16.
  - Load addr 20 -> rsp_err=1, rsp_rdata=0.
  - Store addr 20 with 0xFFFFFFFF -> rsp_err=1; a following load of addr 4 returns its prior value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, default parameters and the byte-lane merge helper for the
// data-memory responder.
package dmem_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 32;
  localparam int LATENCY_DEF = 2;
  localparam int BE_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Lanes with be[i]=1 take new_w, the rest keep old_w.
  function automatic logic [31:0] merge_lanes(input logic [31:0]     old_w,
                                              input logic [31:0]     new_w,
                                              input logic [BE_W-1:0] be);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word store: asynchronous read port, byte-enable write port,
// deliberately without reset so contents survive a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [BE_W-1:0]   wr_be
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] wr_idx_s;

  assign rd_idx_s = rd_addr[IDX_W-1:0];
  assign wr_idx_s = wr_addr[IDX_W-1:0];
  assign rd_data  = mem_q[rd_idx_s];

  // Per-lane write; the caller guarantees wr_addr < DEPTH when wr_en is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_idx_s][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the processor load/store port: one request per handshake,
// LATENCY wait cycles, then a held response until the processor takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [3:0]        LAT_CNT = 4'(LATENCY);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                commit_s;
  logic                in_range_s;
  logic                c_we_s;
  logic [ADDR_W-1:0]   c_addr_s;
  logic [DATA_W-1:0]   c_wdata_s;
  logic [BE_W-1:0]     c_be_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                wr_en_s;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (CLOCK_50),
    .rd_addr (c_addr_s),
    .rd_data (rd_data_s),
    .wr_en   (wr_en_s),
    .wr_addr (c_addr_s),
    .wr_data (c_wdata_s),
    .wr_be   (c_be_s)
  );

  // Next state, capture, commit decision and response update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    commit_s  = 1'b0;
    c_we_s    = we_q;
    c_addr_s  = addr_q;
    c_wdata_s = wdata_q;
    c_be_s    = be_q;

    case (state_q)
      IDLE: begin
        // With zero latency the commit uses the live request fields.
        c_we_s    = req_we;
        c_addr_s  = req_addr;
        c_wdata_s = req_wdata;
        c_be_s    = req_be;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 0) begin
            state_d  = RESP;
            commit_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d  = RESP;
          cnt_d    = 4'd0;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    in_range_s = ({1'b0, c_addr_s} < DEPTH_L);

    if (commit_s) begin
      if (in_range_s) begin
        rdata_d = merge_lanes(rd_data_s, c_wdata_s, c_we_s ? c_be_s : 4'h0);
        err_d   = 1'b0;
      end else begin
        rdata_d = {DATA_W{1'b0}};
        err_d   = 1'b1;
      end
    end else begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end
  end

  assign wr_en_s = commit_s && c_we_s && in_range_s;

  // State, counter, capture and response registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      be_q    <= {BE_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (LATENCY 2/0/4, DEPTH 32/16/16)
// driven by a directed vector table, hand sequences and random traffic.
module tb_dmem_responder;

  logic        clk;
  logic        reset_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [4:0]  req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int n_vec;
  int n_err;

  logic [31:0] ref_mem [3][32];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W  (5),
      .DATA_W  (32),
      .DEPTH   ((g == 0) ? 32 : 16),
      .LATENCY ((g == 0) ? 2 : ((g == 1) ? 0 : 4))
    ) u_dut (
      .CLOCK_50  (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
  endfunction

  function automatic int dep_of(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: the word a transaction returns, updating the model for stores.
  task automatic model_apply(input int k, input bit we, input logic [4:0] a,
                             input logic [31:0] wd, input logic [3:0] be,
                             output logic [31:0] exp_d, output logic exp_e);
    logic [31:0] mask;
    if (int'(a) >= dep_of(k)) begin
      exp_d = 32'h0;
      exp_e = 1'b1;
    end else begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      if (!we) mask = 32'h0;
      exp_d = (ref_mem[k][a] & ~mask) | (wd & mask);
      ref_mem[k][a] = exp_d;
      exp_e = 1'b0;
    end
  endtask

  task automatic accept_only(input int k, input bit we, input logic [4:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
    chk($sformatf("req_ready_idle[%0d]", k), {31'd0, req_ready[k]}, 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_be[k]    = be;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_we[k]    = ~we;
    req_addr[k]  = ~a;
    req_wdata[k] = $urandom;
    req_be[k]    = ~be;
  endtask

  task automatic txn(input int k, input bit we, input logic [4:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er);
    int n;
    rsp_ready[k] = (hold == 0);
    accept_only(k, we, a, wd, be);
    n = 0;
    while (!rsp_valid[k] && n < 40) begin
      chk($sformatf("busy_wait[%0d]", k), {31'd0, busy[k]}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency[%0d]", k), n, lat_of(k));
    rd = rsp_rdata[k];
    er = rsp_err[k];
    for (int i = 0; i < hold; i++) begin
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b1;
      req_addr[k]  = 5'd9;
      req_wdata[k] = 32'hBAD0BAD0;
      req_be[k]    = 4'hF;
      @(posedge clk); #1;
      chk($sformatf("bp_valid[%0d]", k), {31'd0, rsp_valid[k]}, 32'd1);
      chk($sformatf("bp_rdata[%0d]", k), rsp_rdata[k], rd);
      chk($sformatf("bp_err[%0d]", k), {31'd0, rsp_err[k]}, {31'd0, er});
      chk($sformatf("bp_req_ready[%0d]", k), {31'd0, req_ready[k]}, 32'd0);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("after_hs_valid[%0d]", k), {31'd0, rsp_valid[k]}, 32'd0);
    chk($sformatf("after_hs_ready[%0d]", k), {31'd0, req_ready[k]}, 32'd1);
    chk($sformatf("after_hs_busy[%0d]", k), {31'd0, busy[k]}, 32'd0);
    chk($sformatf("idle_hold_rdata[%0d]", k), rsp_rdata[k], rd);
  endtask

  task automatic do_vec(input string name, input int k, input bit we, input logic [4:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input int hold,
                        input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    txn(k, we, a, wd, be, hold, rd, er);
    chk({name, "_rdata"}, rd, exp_d);
    chk({name, "_err"}, {31'd0, er}, {31'd0, exp_e});
  endtask

  task automatic check_reset_vals(input string name);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_req_ready[%0d]", name, k), {31'd0, req_ready[k]}, 32'd1);
      chk($sformatf("%s_rsp_valid[%0d]", name, k), {31'd0, rsp_valid[k]}, 32'd0);
      chk($sformatf("%s_busy[%0d]", name, k), {31'd0, busy[k]}, 32'd0);
      chk($sformatf("%s_rdata[%0d]", name, k), rsp_rdata[k], 32'd0);
      chk($sformatf("%s_err[%0d]", name, k), {31'd0, rsp_err[k]}, 32'd0);
    end
  endtask

  typedef struct {
    string       name;
    int          k;
    bit          we;
    logic [4:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] e_d;
    logic        e_e;
    logic [31:0] rd;
    logic        er;

    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 32; a++) ref_mem[k][a] = 32'h0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 5'd0;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'h0;
      rsp_ready[k] = 1'b1;
    end

    vecs[0]  = '{"store_timing",  0, 1'b1, 5'd3,  32'hDEADBEEF, 4'hF, 0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{"load_back",     0, 1'b0, 5'd3,  32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"partial_store", 0, 1'b1, 5'd3,  32'h0000AA00, 4'h2, 0, 32'hDEADAAEF, 1'b0};
    vecs[3]  = '{"partial_load",  0, 1'b0, 5'd3,  32'h0,        4'h0, 0, 32'hDEADAAEF, 1'b0};
    vecs[4]  = '{"be0_store",     0, 1'b1, 5'd3,  32'hFFFFFFFF, 4'h0, 0, 32'hDEADAAEF, 1'b0};
    vecs[5]  = '{"backpressure",  0, 1'b0, 5'd3,  32'h0,        4'h0, 5, 32'hDEADAAEF, 1'b0};
    vecs[6]  = '{"addr9_intact",  0, 1'b0, 5'd9,  32'h0,        4'h0, 0, 32'h00000000, 1'b0};
    vecs[7]  = '{"lat0_store",    1, 1'b1, 5'd4,  32'hCAFEF00D, 4'hF, 0, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{"lat0_load",     1, 1'b0, 5'd4,  32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{"oor_load",      1, 1'b0, 5'd20, 32'h0,        4'h0, 0, 32'h00000000, 1'b1};
    vecs[10] = '{"oor_store",     1, 1'b1, 5'd20, 32'hFFFFFFFF, 4'hF, 0, 32'h00000000, 1'b1};
    vecs[11] = '{"no_alias",      1, 1'b0, 5'd4,  32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0};
    vecs[12] = '{"top_word",      2, 1'b1, 5'd15, 32'h11223344, 4'hF, 1, 32'h11223344, 1'b0};
    vecs[13] = '{"first_oor",     2, 1'b0, 5'd16, 32'h0,        4'h0, 0, 32'h00000000, 1'b1};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Bring every implemented word to a known zero before directed tests.
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < dep_of(k); a++) begin
        txn(k, 1'b1, 5'(a), 32'h0, 4'hF, 0, rd, er);
      end
    end

    for (int i = 0; i < 14; i++) begin
      model_apply(vecs[i].k, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].be, e_d, e_e);
      do_vec(vecs[i].name, vecs[i].k, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].be,
             vecs[i].hold, vecs[i].exp_d, vecs[i].exp_e);
    end

    // Reset while a store waits: the store must be dropped.
    accept_only(2, 1'b1, 5'd7, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_busy", {31'd0, busy[2]}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_vec("dropped_store", 2, 1'b0, 5'd7, 32'h0, 4'h0, 0, 32'h00000000, 1'b0);

    // Reset while a committed store is held in RESP: the store persists.
    model_apply(0, 1'b1, 5'd10, 32'hA5A5A5A5, 4'hF, e_d, e_e);
    rsp_ready[0] = 1'b0;
    accept_only(0, 1'b1, 5'd10, 32'hA5A5A5A5, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("resp_before_reset", {31'd0, rsp_valid[0]}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("resp_reset_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    do_vec("committed_persists", 0, 1'b0, 5'd10, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0);

    for (int i = 0; i < 150; i++) begin
      int          k;
      bit          we;
      logic [4:0]  a;
      logic [31:0] wd;
      logic [3:0]  be;
      int          hold;
      k    = int'($urandom_range(0, 2));
      we   = 1'($urandom_range(0, 1));
      a    = 5'($urandom_range(0, 31));
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      hold = int'($urandom_range(0, 3));
      model_apply(k, we, a, wd, be, e_d, e_e);
      do_vec($sformatf("rand%0d", i), k, we, a, wd, be, hold, e_d, e_e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
